// File: rtl/config_pkg.sv
// Shared types and constants for the config menu overlay (controller and config_video).
package config_pkg;

  localparam int CFG_V_ACTIVE     = 720;
  localparam int CFG_NUM_ITEMS    = 4;
  localparam int CFG_VAL_WIDTH    = 3;
  localparam int CFG_NUM_VALS     = 8;
  localparam int CFG_REPEAT_DELAY = 20;
  localparam int CFG_REPEAT_RATE  = 4;
  localparam int CFG_HCOUNT_W     = 11;
  localparam int CFG_VCOUNT_W     = 10;

  typedef enum logic [1:0] {
    HIDDEN,
    SHOWN,
    COMMIT
  } menu_state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_START,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } menu_action_t;

endpackage

// File: rtl/config_menu_ctrl_btn_repeat.sv
// One button: rising-edge capture into a pending bit held until the next frame tick,
// plus an optional held-frame counter that synthesizes auto-repeat presses.
module btn_repeat #(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic tick_in,
  input  logic discard_in,
  input  logic btn_in,
  output logic press_out
);

  logic btn_prev_q;
  logic pending_q, pending_d;
  logic rise;
  logic repeat_fire;

  assign rise = btn_in & ~btn_prev_q;

  // NOTE: defaults first, so every path assigns the signal and no latch is inferred.
  always_comb begin
    pending_d = pending_q | rise;
    if (tick_in || discard_in) pending_d = 1'b0;
  end

  // An edge arriving on the tick cycle itself is honoured on that tick.
  assign press_out = tick_in & ~discard_in & (pending_q | rise | repeat_fire);

  // NOTE: clocked state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      btn_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      btn_prev_q <= btn_in;
      pending_q  <= pending_d;
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // After the first repeat the counter reloads so the next one lands REPEAT_RATE ticks later.
      always_comb begin
        cnt_d       = cnt_q;
        repeat_fire = 1'b0;
        if (!btn_in) begin
          cnt_d = '0;
        end else if (tick_in) begin
          if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            repeat_fire = 1'b1;
            cnt_d       = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end else begin : g_no_repeat
      assign repeat_fire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/config_menu_ctrl.sv
// Config menu sequencer: frame-tick navigation of cursor/values and a valid/ready
// commit of the edited values when the menu is closed.
module config_menu_ctrl
  import config_pkg::*;
#(
  parameter int NUM_ITEMS    = CFG_NUM_ITEMS,
  parameter int VAL_WIDTH    = CFG_VAL_WIDTH,
  parameter int NUM_VALS     = CFG_NUM_VALS,
  parameter int V_ACTIVE     = CFG_V_ACTIVE,
  parameter int REPEAT_DELAY = CFG_REPEAT_DELAY,
  parameter int REPEAT_RATE  = CFG_REPEAT_RATE
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [10:0]                      hcount_in,
  input  logic [9:0]                       vcount_in,
  input  logic                             btn_up_in,
  input  logic                             btn_down_in,
  input  logic                             btn_left_in,
  input  logic                             btn_right_in,
  input  logic                             btn_start_in,
  output logic                             menu_active_out,
  output logic [$clog2(NUM_ITEMS)-1:0]     cursor_out,
  output logic [NUM_ITEMS*VAL_WIDTH-1:0]   values_out,
  output logic                             cfg_valid_out,
  input  logic                             cfg_ready_in,
  output logic [NUM_ITEMS*VAL_WIDTH-1:0]   cfg_data_out
);

  localparam int CUR_W = $clog2(NUM_ITEMS);
  localparam logic [CUR_W-1:0]     CUR_LAST = CUR_W'(NUM_ITEMS - 1);
  localparam logic [VAL_WIDTH-1:0] VAL_MAX  = VAL_WIDTH'(NUM_VALS - 1);

  typedef logic [NUM_ITEMS-1:0][VAL_WIDTH-1:0] val_vec_t;

  menu_state_t      state_q, state_d;
  menu_action_t     action;
  logic             tick;
  logic             discard;
  logic             commit_ack;
  logic             press_start, press_up, press_down, press_left, press_right;
  logic [CUR_W-1:0] cursor_q, cursor_d;
  val_vec_t         working_q, working_d;
  val_vec_t         committed_q, committed_d;
  val_vec_t         cfg_data_q, cfg_data_d;
  logic             menu_active_q, menu_active_d;
  logic             cfg_valid_q, cfg_valid_d;

  assign tick       = (hcount_in == '0) && (vcount_in == 10'(V_ACTIVE));
  assign discard    = (state_q == COMMIT);
  assign commit_ack = cfg_valid_q && cfg_ready_in;

  btn_repeat #(.REPEAT_DELAY(0), .REPEAT_RATE(1)) u_start (
    .clk_in, .rst_in, .tick_in(tick), .discard_in(discard), .btn_in(btn_start_in), .press_out(press_start));
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk_in, .rst_in, .tick_in(tick), .discard_in(discard), .btn_in(btn_up_in), .press_out(press_up));
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
    .clk_in, .rst_in, .tick_in(tick), .discard_in(discard), .btn_in(btn_down_in), .press_out(press_down));
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
    .clk_in, .rst_in, .tick_in(tick), .discard_in(discard), .btn_in(btn_left_in), .press_out(press_left));
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
    .clk_in, .rst_in, .tick_in(tick), .discard_in(discard), .btn_in(btn_right_in), .press_out(press_right));

  // One action per tick; lower-priority presses on the same tick are dropped.
  always_comb begin
    action = ACT_NONE;
    if      (press_start) action = ACT_START;
    else if (press_up)    action = ACT_UP;
    else if (press_down)  action = ACT_DOWN;
    else if (press_left)  action = ACT_LEFT;
    else if (press_right) action = ACT_RIGHT;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= HIDDEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HIDDEN:  if (action == ACT_START) state_d = SHOWN;
      SHOWN:   if (action == ACT_START) state_d = COMMIT;
      COMMIT:  if (commit_ack)          state_d = HIDDEN;
      default: state_d = HIDDEN;
    endcase
  end

  always_comb begin
    cursor_d    = cursor_q;
    working_d   = working_q;
    committed_d = committed_q;
    cfg_data_d  = cfg_data_q;
    unique case (state_q)
      HIDDEN: begin
        if (action == ACT_START) begin
          cursor_d  = '0;
          working_d = committed_q;
        end
      end
      SHOWN: begin
        unique case (action)
          ACT_UP:    cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - CUR_W'(1);
          ACT_DOWN:  cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CUR_W'(1);
          ACT_LEFT:  if (working_q[cursor_q] != '0)
                       working_d[cursor_q] = working_q[cursor_q] - VAL_WIDTH'(1);
          ACT_RIGHT: if (working_q[cursor_q] < VAL_MAX)
                       working_d[cursor_q] = working_q[cursor_q] + VAL_WIDTH'(1);
          ACT_START: cfg_data_d = working_q;
          default:   ;
        endcase
      end
      COMMIT:  if (commit_ack) committed_d = working_q;
      default: ;
    endcase
    menu_active_d = (state_d != HIDDEN);
    cfg_valid_d   = (state_d == COMMIT);
  end

  // NOTE: the value arrays are ordinary flops, so they take the async reset like any other register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cursor_q      <= '0;
      working_q     <= '0;
      committed_q   <= '0;
      cfg_data_q    <= '0;
      menu_active_q <= 1'b0;
      cfg_valid_q   <= 1'b0;
    end else begin
      cursor_q      <= cursor_d;
      working_q     <= working_d;
      committed_q   <= committed_d;
      cfg_data_q    <= cfg_data_d;
      menu_active_q <= menu_active_d;
      cfg_valid_q   <= cfg_valid_d;
    end
  end

  assign menu_active_out = menu_active_q;
  assign cursor_out      = cursor_q;
  assign values_out      = working_q;
  assign cfg_valid_out   = cfg_valid_q;
  assign cfg_data_out    = cfg_data_q;

endmodule

// File: tb/tb_config_menu_ctrl.sv
// Bench for config_menu_ctrl: directed scenarios with literal expectations plus randomized
// buttons/ready, all compared every cycle against a frame-level behavioural model.
module tb_config_menu_ctrl;

  localparam int NI = 4, VW = 3, NV = 8, VA = 720, RD = 20, RR = 4;
  localparam int FL = 8;  // clock cycles per simulated frame; position 0 is the tick

  logic clk_in = 1'b0;
  logic rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [4:0]  btn;  // 0 start, 1 up, 2 down, 3 left, 4 right
  logic btn_up_in, btn_down_in, btn_left_in, btn_right_in, btn_start_in;
  logic cfg_ready_in;
  logic menu_active_out, cfg_valid_out;
  logic [1:0] cursor_out;
  logic [NI*VW-1:0] values_out, cfg_data_out;

  assign btn_start_in = btn[0];
  assign btn_up_in    = btn[1];
  assign btn_down_in  = btn[2];
  assign btn_left_in  = btn[3];
  assign btn_right_in = btn[4];

  always #5 clk_in = ~clk_in;

  config_menu_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .btn_up_in(btn_up_in), .btn_down_in(btn_down_in), .btn_left_in(btn_left_in),
    .btn_right_in(btn_right_in), .btn_start_in(btn_start_in),
    .menu_active_out(menu_active_out), .cursor_out(cursor_out), .values_out(values_out),
    .cfg_valid_out(cfg_valid_out), .cfg_ready_in(cfg_ready_in), .cfg_data_out(cfg_data_out));

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  int fpos     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: menu visibility, commit pending, cursor and value arrays as plain integers.
  bit m_vis, m_com;
  int m_cur;
  int m_work[NI], m_comm[NI], m_data[NI];
  bit m_pend[5], m_prev[5];
  int m_held[5];

  function automatic logic [NI*VW-1:0] pack(input int a[NI]);
    logic [NI*VW-1:0] r;
    r = '0;
    for (int i = 0; i < NI; i++) r[i*VW +: VW] = VW'(a[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_vis = 0; m_com = 0; m_cur = 0;
    for (int i = 0; i < NI; i++) begin m_work[i] = 0; m_comm[i] = 0; m_data[i] = 0; end
    for (int i = 0; i < 5; i++) begin m_pend[i] = 0; m_prev[i] = 0; m_held[i] = 0; end
  endtask

  // Advance the model by one clock, using the inputs the DUT sampled on this edge.
  task automatic model_step();
    bit tick, was_com, rise, fire;
    bit req[5];
    int act, k;
    if (rst_in) begin model_reset(); return; end
    tick    = (hcount_in == 0) && (vcount_in == VA);
    was_com = m_com;
    for (int i = 0; i < 5; i++) begin
      rise = btn[i] && !m_prev[i];
      fire = 0;
      if (i > 0 && btn[i] && tick) begin
        k    = m_held[i] + 1;  // ordinal of this held tick
        fire = (k >= RD) && ((k - RD) % RR == 0);
      end
      req[i] = tick && !was_com && (m_pend[i] || rise || fire);
      if (!btn[i]) m_held[i] = 0;
      else if (tick) m_held[i]++;
      m_pend[i] = (tick || was_com) ? 1'b0 : (m_pend[i] || rise);
      m_prev[i] = btn[i];
    end
    act = -1;
    for (int i = 4; i >= 0; i--) if (req[i]) act = i;
    if (was_com) begin
      if (cfg_ready_in) begin m_comm = m_work; m_com = 0; m_vis = 0; end
    end else if (m_vis) begin
      case (act)
        0: begin m_com = 1; m_data = m_work; end
        1: m_cur = (m_cur + NI - 1) % NI;
        2: m_cur = (m_cur + 1) % NI;
        3: if (m_work[m_cur] > 0) m_work[m_cur]--;
        4: if (m_work[m_cur] < NV - 1) m_work[m_cur]++;
        default: ;
      endcase
    end else if (act == 0) begin
      m_vis = 1; m_cur = 0; m_work = m_comm;
    end
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("menu_active", {31'd0, menu_active_out}, {31'd0, m_vis});
      check("cursor", {30'd0, cursor_out}, m_cur);
      check("values", {20'd0, values_out}, {20'd0, pack(m_work)});
      check("cfg_valid", {31'd0, cfg_valid_out}, {31'd0, m_com});
      if (m_com) check("cfg_data", {20'd0, cfg_data_out}, {20'd0, pack(m_data)});
    end
  end

  task automatic set_timing();
    if (fpos == 0) begin
      hcount_in = 11'd0; vcount_in = 10'(VA);
    end else begin
      case ($urandom_range(2))
        0:       begin hcount_in = 11'd0; vcount_in = 10'($urandom_range(719)); end
        1:       begin hcount_in = 11'($urandom_range(1, 1999)); vcount_in = 10'(VA); end
        default: begin hcount_in = 11'($urandom_range(1, 1999)); vcount_in = 10'd300; end
      endcase
    end
  endtask

  task automatic cyc();
    set_timing();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    fpos = (fpos + 1) % FL;
  endtask

  task automatic run_frame();
    do cyc(); while (fpos != 1);
  endtask

  task automatic align();
    while (fpos != 1) cyc();
  endtask

  // Short press mid-frame; returns just after the following tick has taken effect.
  task automatic tap(input int i);
    cyc(); btn[i] = 1'b1; cyc(); cyc(); btn[i] = 1'b0;
    while (fpos != 0) cyc();
    cyc();
  endtask

  initial begin
    rst_in = 1'b1; btn = '0; cfg_ready_in = 1'b0;
    hcount_in = 11'd5; vcount_in = 10'd300;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("reset_active", {31'd0, menu_active_out}, 0);
    check("reset_valid", {31'd0, cfg_valid_out}, 0);
    check("reset_cursor", {30'd0, cursor_out}, 0);
    check("reset_values", {20'd0, values_out}, 0);
    rst_in = 1'b0; fpos = 1; cmp_en = 1'b1;

    // Open, then walk the cursor with wrap in both directions.
    tap(0);
    check("open_active", {31'd0, menu_active_out}, 1);
    check("open_cursor", {30'd0, cursor_out}, 0);
    tap(2);
    check("down1", {30'd0, cursor_out}, 1);
    cyc(); btn[2] = 1'b1; cyc(); btn[2] = 1'b0;
    check("no_change_midframe", {30'd0, cursor_out}, 1);
    while (fpos != 0) cyc();
    check("no_change_before_tick", {30'd0, cursor_out}, 1);
    cyc();
    check("down2_after_tick", {30'd0, cursor_out}, 2);
    tap(2);
    check("down3", {30'd0, cursor_out}, 3);
    tap(2);
    check("down_wrap", {30'd0, cursor_out}, 0);
    tap(1);
    check("up_wrap", {30'd0, cursor_out}, 3);
    tap(2); tap(2); tap(2);
    check("cursor_item2", {30'd0, cursor_out}, 2);

    // Hold right on item 2: +1 at the first tick, then repeats at held ticks 20, 24, ...
    cyc(); btn[4] = 1'b1;
    while (fpos != 0) cyc();
    cyc();
    check("right_tick1", {29'd0, values_out[2*VW +: VW]}, 1);
    repeat (18) run_frame();
    check("right_tick19", {29'd0, values_out[2*VW +: VW]}, 1);
    run_frame();
    check("right_tick20", {29'd0, values_out[2*VW +: VW]}, 2);
    repeat (4) run_frame();
    check("right_tick24", {29'd0, values_out[2*VW +: VW]}, 3);
    repeat (36) run_frame();
    check("right_clamp", {29'd0, values_out[2*VW +: VW]}, NV - 1);
    check("right_others", {20'd0, values_out & ~12'h1C0}, 0);

    btn[4] = 1'b0; cyc(); btn[3] = 1'b1;
    while (fpos != 0) cyc();
    cyc();
    check("left_tick1", {29'd0, values_out[2*VW +: VW]}, 6);
    repeat (59) run_frame();
    check("left_clamp", {29'd0, values_out[2*VW +: VW]}, 0);
    btn[3] = 1'b0;
    align();
    tap(4); tap(4);
    check("right_taps", {20'd0, values_out}, 12'h080);

    // Same-frame up and right: only the cursor moves, and the right press is not carried over.
    cyc(); btn[1] = 1'b1; btn[4] = 1'b1; cyc(); btn[1] = 1'b0; btn[4] = 1'b0;
    while (fpos != 0) cyc();
    cyc();
    check("prio_cursor", {30'd0, cursor_out}, 1);
    check("prio_values", {20'd0, values_out}, 12'h080);
    run_frame();
    check("prio_pending_cleared", {20'd0, values_out}, 12'h080);

    // Commit with the consumer stalled, then accept and reopen.
    tap(0);
    check("commit_valid", {31'd0, cfg_valid_out}, 1);
    check("commit_active", {31'd0, menu_active_out}, 1);
    btn[2] = 1'b1; repeat (3) cyc(); btn[2] = 1'b0;
    repeat (10) cyc();
    check("stall_valid", {31'd0, cfg_valid_out}, 1);
    check("stall_data", {20'd0, cfg_data_out}, 12'h080);
    check("stall_cursor", {30'd0, cursor_out}, 1);
    cfg_ready_in = 1'b1; cyc(); cfg_ready_in = 1'b0;
    check("ack_valid_low", {31'd0, cfg_valid_out}, 0);
    check("ack_hidden", {31'd0, menu_active_out}, 0);
    align();
    tap(0);
    check("reopen_active", {31'd0, menu_active_out}, 1);
    check("reopen_cursor", {30'd0, cursor_out}, 0);
    check("reopen_values", {20'd0, values_out}, 12'h080);

    // Randomized buttons and consumer readiness.
    repeat (4000) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(59) == 0) btn[i] = ~btn[i];
      cfg_ready_in = ($urandom_range(3) == 0);
      cyc();
    end

    // Drive into COMMIT, then reset asynchronously while valid is high.
    btn = '0; cfg_ready_in = 1'b0;
    align(); run_frame();
    if (!m_vis) tap(0);
    if (!m_com) tap(0);
    check("pre_reset_valid", {31'd0, cfg_valid_out}, 1);
    #2 rst_in = 1'b1;
    model_reset();
    #1;
    check("async_rst_valid", {31'd0, cfg_valid_out}, 0);
    check("async_rst_active", {31'd0, menu_active_out}, 0);
    check("async_rst_cursor", {30'd0, cursor_out}, 0);
    check("async_rst_values", {20'd0, values_out}, 0);
    cyc(); cyc();
    rst_in = 1'b0;
    repeat (2 * FL) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
